adc_averager_scaler: RTL and testbench
======================================

// Module: adc_averager_scaler
// PURPOSE
//  Conditions one ADC channel (XADC, PWM ramp or R2R) ahead of the menu subsystem's averaging mux.
//  Takes strobed raw conversion codes and produces three 16-bit views for the menu's 3-way select:
//  - raw: held latest code
//  - ave: moving average over the last 2^LOG2_N samples
//  - scaled: the average converted to millivolts
//  One instance per ADC channel; enable is driven by that channel's menu enable (XADC_EN/PWM_EN/R2R_EN).
// PARAMETERS
//  DATA_W      12    width of incoming conversion code (<=16)
//  LOG2_N      8     log2 of averaging window (window N = 2^LOG2_N samples, 1..10)
//  SCALE_NUM   1000  full-scale value in mV (multiplier)
//  SCALE_SHIFT 12    right shift after multiply (normally = DATA_W)
// PORTS
//  clk          in   1       system clock
//  reset        in   1       asynchronous, active-high reset
//  enable       in   1       channel enable; low = idle, pipeline flushed
//  sample_valid in   1       one-cycle strobe, sample_in valid
//  sample_in    in   DATA_W  raw conversion code
//  raw_out      out  16      latest accepted code, zero-extended
//  ave_out      out  16      moving average, zero-extended
//  scaled_out   out  16      average in mV, saturated
//  out_valid    out  1       one-cycle pulse when ave_out/scaled_out update
//  window_full  out  1       high once N samples are held since last (re)start
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high (ports clk, reset).
//  Reset: all outputs 0; state IDLE; sum, fill count and write pointer 0. Buffer RAM is not cleared.
//  A sample is accepted iff enable && sample_valid at a rising edge.
//  Accepts back-to-back samples every cycle; no backpressure.
//  FSM:
//  - IDLE -> FILL when enable = 1.
//  - FILL -> RUN on the N-th accepted sample.
//  - Any state -> IDLE when enable = 0.
//  - Entering IDLE clears sum, count and pointer, and drops window_full.
//  - raw_out, ave_out and scaled_out hold their last values while in IDLE.
//  Ring buffer: 2^LOG2_N x DATA_W, read-first RAM.
//  - On accept: read buf[wr_ptr] (oldest) and write sample_in to the same address in the same edge.
//  - wr_ptr wraps from N-1 to 0.
//  Running sum: DATA_W+LOG2_N bits. sum <= sum + new - oldest.
//  - In FILL, oldest is forced to 0 (RAM contents are stale).
//  - Never overflows by construction.
//  Average: ave = sum >> LOG2_N (truncating), DATA_W bits.
//  Scaling: scaled = (ave * SCALE_NUM) >> SCALE_SHIFT, using a DATA_W+16-bit product.
//  - Result saturates to 16'hFFFF if it exceeds 16 bits.
//  Latency, for a sample accepted at edge k:
//  - raw_out updates at k+1 (every accept, all states except IDLE).
//  - sum updates at k+2.
//  - ave_out, scaled_out and out_valid update together at k+3.
//  out_valid pulses only for samples accepted in RUN, or for the N-th sample (the FILL->RUN transition).
//  - In FILL before that, ave_out and scaled_out stay at their previous values.
//  window_full rises at the same edge as the first out_valid.
//  Enable falling with samples in flight: in-flight results are discarded, with no out_valid pulse.
//  Reset asserted mid-operation: immediate clear; the pipeline restarts in IDLE after reset release.
// STRUCTURE
//  Shared package adc_pkg:
//  - ADC_DATA_W = 12
//  - typedef enum logic [1:0] {IDLE, FILL, RUN} avg_state_t
//  - MV_FULL_SCALE = 1000
//  - typedef logic [15:0] disp_word_t (the 16-bit word fed to the menu muxes)
//  Sub-module sample_ring_buffer:
//  - Single-port read-first RAM, parameters DEPTH_LOG2 and WIDTH.
//  - Registered read data; infers BRAM/LUTRAM.
//  Top level: FSM, counters, sum, and scale pipeline.
// TESTING (bench overrides LOG2_N=2, N=4 unless stated)
//  1 Reset: assert mid-stream -> all outputs 0 and window_full 0 in the same cycle; no out_valid until 4 new samples after release.
//  2 Fill: four samples of 2048 -> first out_valid 3 cycles after the 4th accept; ave_out=2048, scaled_out=500, window_full=1.
//  3 Step + wrap: continue with four samples of 4095 -> ave_out = 2559, 3071, 3583, 4095; final scaled_out=999; pointer wraps correctly.
//  4 Back-to-back: sample_valid held high for 16 cycles with ramp 0..15 -> out_valid on cycles for samples 3..15; ave = (s-3+...+s)>>2 (e.g. 13 for s=15).
//  5 Enable drop: deassert enable one cycle after an accept in RUN -> no out_valid; outputs hold; re-enable -> FILL again, needs 4 samples.
//  6 Saturation: SCALE_NUM=65535, SCALE_SHIFT=0, constant 4095 -> scaled_out=16'hFFFF.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared ADC channel constants and types used by the averaging/scaling front end.
package adc_pkg;

    localparam int ADC_DATA_W    = 12;
    localparam int MV_FULL_SCALE = 1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } avg_state_t;

    typedef logic [15:0] disp_word_t;

endpackage

// File: rtl/sample_ring_buffer.sv
// Purpose: single-port read-first sample RAM holding the averaging window.
// Latency: 1 cycle registered read; the old word at addr is returned while the new one is written.
// Backpressure: none; one access per cycle whenever en is high.
module sample_ring_buffer #(
    parameter int DEPTH_LOG2 = 8,
    parameter int WIDTH      = 12
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WIDTH-1:0]      wr_dat,
    output logic [WIDTH-1:0]      rd_dat
);

    logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // No reset: contents are treated as stale until the window has been refilled.
    always_ff @(posedge clk) begin
        if (en) begin
            rd_dat    <= mem[addr];
            mem[addr] <= wr_dat;
        end
    end

endmodule

// File: rtl/adc_averager_scaler.sv
// Purpose: per-channel ADC conditioning -> held raw code, moving average over 2^LOG2_N samples, average in mV.
// Latency: raw_out 1 cycle after accept, ave_out/scaled_out/out_valid 3 cycles after accept.
// Backpressure: none; accepts a sample every cycle, enable low flushes the pipeline.
module adc_averager_scaler
    import adc_pkg::*;
#(
    parameter int DATA_W      = ADC_DATA_W,
    parameter int LOG2_N      = 8,
    parameter int SCALE_NUM   = MV_FULL_SCALE,
    parameter int SCALE_SHIFT = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    output disp_word_t        raw_out,
    output disp_word_t        ave_out,
    output disp_word_t        scaled_out,
    output logic              out_valid,
    output logic              window_full
);

    localparam int SUM_W  = DATA_W + LOG2_N;
    localparam int PROD_W = DATA_W + 16;

    avg_state_t        state;
    logic [LOG2_N-1:0] wr_ptr;
    logic              accept;
    logic              last_fill;
    logic [DATA_W-1:0] rd_dat;

    logic              s1_acc, s1_fill, s1_out;
    logic [DATA_W-1:0] s1_new;
    logic              s2_acc, s2_out;
    logic [DATA_W-1:0] s2_new, s2_old;
    logic              s3_out;
    logic [SUM_W-1:0]  sum;

    logic [DATA_W-1:0] ave;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] prod_shr;
    disp_word_t        scaled;

    assign accept = enable && sample_valid;
    // Until the window is full the write pointer doubles as the fill count.
    assign last_fill = (state != RUN) && (&wr_ptr);

    sample_ring_buffer #(
        .DEPTH_LOG2 (LOG2_N),
        .WIDTH      (DATA_W)
    ) u_ring (
        .clk    (clk),
        .en     (accept),
        .addr   (wr_ptr),
        .wr_dat (sample_in),
        .rd_dat (rd_dat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
        end else if (!enable) begin
            state  <= IDLE;
            wr_ptr <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (accept && last_fill) begin
                state <= RUN;
            end else if (state == IDLE) begin
                state <= FILL;
            end
        end
    end

    assign ave      = sum[SUM_W-1:LOG2_N];
    assign prod     = PROD_W'(ave) * PROD_W'(SCALE_NUM);
    assign prod_shr = prod >> SCALE_SHIFT;
    assign scaled   = (|prod_shr[PROD_W-1:16]) ? 16'hFFFF : prod_shr[15:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_acc      <= 1'b0;
            s1_fill     <= 1'b0;
            s1_out      <= 1'b0;
            s1_new      <= '0;
            s2_acc      <= 1'b0;
            s2_out      <= 1'b0;
            s2_new      <= '0;
            s2_old      <= '0;
            s3_out      <= 1'b0;
            sum         <= '0;
            raw_out     <= '0;
            ave_out     <= '0;
            scaled_out  <= '0;
            out_valid   <= 1'b0;
            window_full <= 1'b0;
        end else if (!enable) begin
            // In-flight samples are dropped; display words keep their last values.
            s1_acc      <= 1'b0;
            s1_out      <= 1'b0;
            s2_acc      <= 1'b0;
            s2_out      <= 1'b0;
            s3_out      <= 1'b0;
            sum         <= '0;
            out_valid   <= 1'b0;
            window_full <= 1'b0;
        end else begin
            s1_acc  <= accept;
            s1_new  <= sample_in;
            s1_fill <= (state != RUN);
            s1_out  <= (state == RUN) || last_fill;

            if (s1_acc) begin
                raw_out <= 16'(s1_new);
            end
            s2_acc <= s1_acc;
            s2_out <= s1_acc && s1_out;
            s2_new <= s1_new;
            // RAM words are stale while filling, so nothing is retired from the sum.
            s2_old <= s1_fill ? '0 : rd_dat;

            if (s2_acc) begin
                sum <= sum + SUM_W'(s2_new) - SUM_W'(s2_old);
            end
            s3_out <= s2_out;

            out_valid <= s3_out;
            if (s3_out) begin
                ave_out     <= 16'(ave);
                scaled_out  <= scaled;
                window_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_averager_scaler.sv
// Directed bench for adc_averager_scaler with a scoreboard of expected averages keyed by output cycle.
module tb_adc_averager_scaler;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sample_valid;
    logic [11:0] sample_in;

    logic [15:0] raw_out, ave_out, scaled_out;
    logic        out_valid, window_full;
    logic [15:0] raw_sat, ave_sat, scaled_sat;
    logic        out_valid_sat, window_full_sat;

    typedef struct {
        int cyc;
        int ave;
        int scaled;
    } exp_t;

    exp_t q[$];
    int   win[$];
    int   edge_n   = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    adc_averager_scaler #(
        .DATA_W(12), .LOG2_N(2), .SCALE_NUM(1000), .SCALE_SHIFT(12)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
        .sample_in(sample_in), .raw_out(raw_out), .ave_out(ave_out),
        .scaled_out(scaled_out), .out_valid(out_valid), .window_full(window_full)
    );

    adc_averager_scaler #(
        .DATA_W(12), .LOG2_N(2), .SCALE_NUM(65535), .SCALE_SHIFT(0)
    ) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
        .sample_in(sample_in), .raw_out(raw_sat), .ave_out(ave_sat),
        .scaled_out(scaled_sat), .out_valid(out_valid_sat), .window_full(window_full_sat)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        assert (act === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Drive one cycle of inputs, let the edge happen, then advance the reference model.
    task automatic step(input logic en, input logic vld, input int dat);
        int s;
        enable       = en;
        sample_valid = vld;
        sample_in    = 12'(dat);
        @(posedge clk);
        edge_n++;
        if (en && vld) begin
            win.push_back(dat);
            if (win.size() > N) void'(win.pop_front());
            if (win.size() == N) begin
                s = 0;
                foreach (win[i]) s += win[i];
                q.push_back('{cyc: edge_n + 3, ave: s / N, scaled: ((s / N) * 1000) >> 12});
            end
        end
        if (!en) begin
            win.delete();
            while (q.size() > 0 && q[q.size()-1].cyc >= edge_n) void'(q.pop_back());
        end
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_valid_cycle", edge_n, e.cyc);
                    chk("ave_out", int'(ave_out), e.ave);
                    chk("scaled_out", int'(scaled_out), e.scaled);
                    chk("window_full_at_valid", int'(window_full), 1);
                end
            end else if (q.size() > 0 && q[0].cyc <= edge_n) begin
                chk("missing_out_valid", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_raw", int'(raw_out), 0);
        chk("rst_ave", int'(ave_out), 0);
        chk("rst_scaled", int'(scaled_out), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_full", int'(window_full), 0);
        reset = 1'b0;

        // Mid-stream reset clears outputs immediately.
        step(1, 1, 100);
        step(1, 1, 200);
        chk("raw_latency", int'(raw_out), 100);
        reset = 1'b1;
        #1;
        chk("midrst_raw", int'(raw_out), 0);
        chk("midrst_full", int'(window_full), 0);
        chk("midrst_valid", int'(out_valid), 0);
        win.delete();
        q.delete();
        #2;
        reset = 1'b0;

        // Fill with 2048.
        for (int i = 0; i < 4; i++) step(1, 1, 2048);
        repeat (4) step(1, 0, 0);
        chk("fill_ave", int'(ave_out), 2048);
        chk("fill_scaled", int'(scaled_out), 500);
        chk("fill_full", int'(window_full), 1);

        // Step to 4095 across a pointer wrap.
        for (int i = 0; i < 4; i++) step(1, 1, 4095);
        repeat (4) step(1, 0, 0);
        chk("step_ave", int'(ave_out), 4095);
        chk("step_scaled", int'(scaled_out), 999);
        chk("step_raw", int'(raw_out), 4095);

        // Restart, then back-to-back ramp.
        step(0, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 1, i);
        repeat (4) step(1, 0, 0);
        chk("ramp_ave", int'(ave_out), 13);
        chk("ramp_raw", int'(raw_out), 15);

        // Enable drops one cycle after an accept in RUN.
        step(1, 1, 1000);
        step(0, 0, 0);
        repeat (4) step(0, 0, 0);
        chk("drop_raw_hold", int'(raw_out), 15);
        chk("drop_ave_hold", int'(ave_out), 13);
        chk("drop_full", int'(window_full), 0);
        for (int i = 0; i < 3; i++) step(1, 1, 400);
        repeat (5) step(1, 0, 0);
        chk("refill_full", int'(window_full), 0);
        chk("refill_ave_hold", int'(ave_out), 13);
        step(1, 1, 400);
        repeat (4) step(1, 0, 0);
        chk("refill_ave", int'(ave_out), 400);
        chk("refill_full_up", int'(window_full), 1);

        // Saturation on the wide-scale instance.
        for (int i = 0; i < 4; i++) step(1, 1, 4095);
        repeat (4) step(1, 0, 0);
        chk("sat_scaled", int'(scaled_sat), 16'hFFFF);
        chk("sat_ave", int'(ave_sat), 4095);
        chk("nosat_scaled", int'(scaled_out), 999);

        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
